// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// | Module  : fetch_pkg                                                      |
// | Brief   : Shared widths and the prefetch entry type for instruction fetch|
// | Rev     : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// | Module  : fetch_fifo                                                     |
// | Brief   : Prefetch FIFO with sync flush; push into full legal with pop   |
// | Rev     : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  fetch_entry_t             i_data,
  output fetch_entry_t             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are power-of-two wide, so increment wraps modulo DEPTH.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : instr_fetch_ctrl                                               |
// | Brief   : Fetch PC sequencing, redirect flush and prefetch to decode     |
// | Rev     : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 512,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  output logic [31:0]                   imem_addr,
  input  logic [INSTR_W-1:0]            imem_data,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          if_valid,
  input  logic                          if_ready,
  output logic [INSTR_W-1:0]            if_instr,
  output logic [31:0]                   if_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic          w_pop;
  logic          w_enq;
  logic [32:0]   w_pc_inc;
  logic [31:0]   w_pc_next;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_head;
  logic          w_unused_rpc;

  assign w_pop = if_valid & if_ready;
  assign w_enq = fetch_en & ~redirect_valid &
                 ((fifo_count < CNT_W'(FIFO_DEPTH)) | w_pop);

  // Widened add so a redirect near the top of the address space still wraps.
  assign w_pc_inc  = {1'b0, r_fetch_pc} + 33'(PC_STEP);
  assign w_pc_next = (w_pc_inc >= 33'(MEM_BYTES)) ? 32'h0 : w_pc_inc[31:0];

  assign w_unused_rpc = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_enq) begin
      r_fetch_pc <= w_pc_next;
    end
  end

  assign w_wr_entry.instr = imem_data;
  assign w_wr_entry.pc    = r_fetch_pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_data  (w_wr_entry),
    .o_data  (w_head),
    .o_count (fifo_count)
  );

  assign imem_addr = r_fetch_pc;
  assign if_valid  = (fifo_count != '0);
  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// | Module  : tb_instr_fetch_ctrl                                            |
// | Brief   : Scoreboard bench for instr_fetch_ctrl                          |
// | Rev     : 1.0 - initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_ctrl;

  localparam int MEM_BYTES = 512;
  localparam int DEPTH     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  fifo_count;

  logic [31:0] mem [0:MEM_BYTES/4-1];
  logic [63:0] sb [$];
  logic [31:0] popped [$];
  logic [31:0] m_pc;
  int          m_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[8:2]];

  instr_fetch_ctrl #(
    .RESET_PC   (32'h0),
    .MEM_BYTES  (MEM_BYTES),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fifo_count     (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check settled outputs, drive inputs, advance model, cross the edge.
  task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic        pop;
    logic        enq;
    logic [63:0] e;
    @(negedge clk);
    chk("imem_addr", imem_addr, m_pc);
    chk("fifo_count", 32'(fifo_count), 32'(m_cnt));
    chk("if_valid", 32'(if_valid), 32'(m_cnt != 0));
    pop = (m_cnt != 0) && rdy;
    if (pop) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'h0, 32'h1);
      end else begin
        e = sb.pop_front();
        chk("if_instr", if_instr, e[63:32]);
        chk("if_pc", if_pc, e[31:0]);
        popped.push_back(if_pc);
      end
    end
    fetch_en       = fe;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    enq = fe && !rv && ((m_cnt < DEPTH) || pop);
    if (rv) begin
      sb.delete();
      m_cnt = 0;
      m_pc  = {rpc[31:2], 2'b00};
    end else begin
      if (pop) m_cnt--;
      if (enq) begin
        sb.push_back({mem[m_pc[8:2]], m_pc});
        m_cnt++;
        m_pc = (m_pc + 32'd4 >= 32'(MEM_BYTES)) ? 32'h0 : m_pc + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt = 0;
    m_pc  = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES/4; i++) mem[i] = 32'hA500_0000 | 32'(i * 7);
    mem[0] = 32'h0043_0820;
    mem[1] = 32'h0043_0822;
    mem[2] = 32'h0062_0820;
    model_reset();

    @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    rst = 1'b0;

    // Straight-line fetch with decode always ready.
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("first_valid", 32'(if_valid), 32'h1);
    chk("first_instr", if_instr, 32'h0043_0820);
    chk("first_pc", if_pc, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure after restarting at 0.
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("bp_count", 32'(fifo_count), 32'h2);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_instr", if_instr, 32'h0043_0820);
    chk("bp_pc", if_pc, 32'h0);

    // Redirect with a full FIFO; low target bits are dropped.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_000A);
    #1;
    chk("rd_valid", 32'(if_valid), 32'h0);
    chk("rd_addr", imem_addr, 32'h8);
    chk("rd_count", 32'(fifo_count), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rd_instr", if_instr, 32'h0062_0820);
    chk("rd_pc", if_pc, 32'h8);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Wrap at the top of memory.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_01FC);
    popped.delete();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_n", 32'(popped.size() >= 3), 32'h1);
    if (popped.size() >= 3) begin
      chk("wrap_pc0", popped[0], 32'h1FC);
      chk("wrap_pc1", popped[1], 32'h000);
      chk("wrap_pc2", popped[2], 32'h004);
    end

    // Fetch disabled: FIFO drains, PC freezes.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("drain_valid", 32'(if_valid), 32'h0);
    chk("drain_addr", imem_addr, m_pc);

    // Random traffic, including redirects coincident with pops.
    for (int i = 0; i < 200; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 11) == 0), 32'($urandom_range(0, MEM_BYTES - 1)));
    end

    // Asynchronous reset between edges.
    #2;
    fetch_en = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if_valid), 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_count", 32'(fifo_count), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences the byte-addressed, combinational-read instruction memory. Owns the fetch PC and drives it as the memory address. Captures the returned big-endian 32-bit word into a small prefetch FIFO and presents {instruction, pc} to decode over a valid/ready handshake. Supports pipeline redirects (branch/jump) with a full flush and a global fetch enable.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC after reset
MEM_BYTES, 512, instruction memory size in bytes; the fetch PC wraps to 0 at this bound
FIFO_DEPTH, 2, prefetch entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  allows new fetches when high
imem_addr  out  32  byte address to instruction memory (= fetch PC)
imem_data  in  32  instruction word returned combinationally for imem_addr
redirect_valid  in  1  flush and load a new PC this cycle
redirect_pc  in  32  target PC; bits [1:0] ignored
if_valid  out  1  head entry is valid
if_ready  in  1  decode accepts head entry
if_instr  out  32  head instruction word
if_pc  out  32  PC of head instruction
fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy (debug/verification)

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, FIFO empty, if_valid=0, if_instr=0, if_pc=0, fifo_count=0. Takes effect immediately mid-operation; fetch resumes on the first rising clk edge after rst deasserts.
- imem_addr = fetch_pc, combinationally, at all times. The memory is zero-latency, so imem_data is sampled on the same edge.
- pop = if_valid & if_ready.
- enq = fetch_en & ~redirect_valid & (count<FIFO_DEPTH | pop). Enqueue into a full FIFO is legal when a pop occurs in the same cycle.
- On enq: the entry {imem_data, fetch_pc} is written at the tail. fetch_pc <= fetch_pc+4, or 0 if fetch_pc+4 >= MEM_BYTES (wrap).
- No enq: fetch_pc holds.
- Redirect (priority over everything except reset):
  - FIFO is flushed: count<=0, pointers reset, so if_valid=0 on the next cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No enqueue that cycle.
  - A pop coincident with a redirect is still a valid handoff to decode. Discarding it is decode's responsibility.
- Output: if_valid = (count!=0). if_instr and if_pc show the head entry. When empty, they hold their last value; the bench must not check them while if_valid=0.
- Stability: while if_valid=1 and if_ready=0, if_instr and if_pc must not change, except when a redirect flushes the FIFO.
- Latency: 1 cycle from the fetch edge to if_valid. In steady state with if_ready=1 throughout, one instruction per cycle.
- Occupancy: count never exceeds FIFO_DEPTH. count' = count + enq - pop, or 0 on redirect.
- fetch_en=0: no enqueues. Pops continue, so the FIFO drains.
- Pointer wrap: head and tail pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package fetch_pkg: INSTR_W=32, PC_STEP=4, and a typedef fetch_entry_t {instr[31:0], pc[31:0]}.
- One sub-module, fetch_fifo: a synchronous FIFO with async active-high reset, a sync flush, push/pop and simultaneous push+pop at full.
- Top level holds the PC register, wrap logic and enqueue/redirect control.

Test Plan:
- Memory words 0x00430820 @0, 0x00430822 @4, 0x00620820 @8. Release reset with if_ready=1 and fetch_en=1 -> if_valid rises 1 cycle later. Consecutive outputs are (0x00430820,pc=0), (0x00430822,pc=4), (0x00620820,pc=8).
- Backpressure: if_ready=0 for 5 cycles -> fifo_count saturates at 2, imem_addr stops at 8, and the head holds (0x00430820,0). Raise if_ready -> in-order delivery with no loss or duplication.
- Redirect: redirect_valid=1, redirect_pc=0x0000000A, with FIFO holding 2 entries -> next cycle if_valid=0, imem_addr=0x8, fifo_count=0. The following cycle outputs (0x00620820,8).
- Wrap: redirect to 0x1FC (MEM_BYTES=512) -> the fetched PC sequence is 0x1FC, 0x000, 0x004.
- fetch_en=0 with 2 entries and if_ready=1 -> the 2 entries drain, then if_valid=0 and imem_addr stays frozen.
- Async reset asserted mid-stream between clock edges -> if_valid=0, imem_addr=RESET_PC and fifo_count=0 immediately, before the next edge.
